// File: rtl/lamp_level_encoder.sv
// Lamp-level encoder: synchronises 16 lamp lines, waits for them to settle, scans them bit-serially and
// offers the lit level on a valid/ready handshake. Define BUBBLE_TOLERANT_EN to count all lit lamps.
module lamp_level_encoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] lamp_in,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [3:0]  code,
  output logic        overflow,
  output logic        bubble_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_SCAN,
    ST_HOLD
  } state_e;

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0][15:0] sync_q;
  logic [15:0]                  lamp_s;
  logic [15:0]                  prev_q;

  state_e      state_q, state_d;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic [15:0] snap_q, snap_d;
  logic [15:0] last_rep_q, last_rep_d;
  logic        reported_q, reported_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  level_q, level_d;
  logic        run_q, run_d;
  logic        bub_q, bub_d;
  logic [3:0]  code_q, code_d;
  logic        overflow_q, overflow_d;
  logic        bubble_err_q, bubble_err_d;
  logic        scan_bit;

  assign lamp_s = sync_q[SYNC_STAGES-1];

  // NOTE: the synchroniser is a plain register chain, not a memory, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, which is what makes this a shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], lamp_in};
      prev_q <= lamp_s;
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case can infer a latch.
    state_d      = state_q;
    stab_cnt_d   = stab_cnt_q;
    snap_d       = snap_q;
    last_rep_d   = last_rep_q;
    reported_d   = reported_q;
    idx_d        = idx_q;
    level_d      = level_q;
    run_d        = run_q;
    bub_d        = bub_q;
    code_d       = code_q;
    overflow_d   = overflow_q;
    bubble_err_d = bubble_err_q;
    scan_bit     = 1'b0;

    case (state_q)
      ST_SETTLE: begin
        if (lamp_s == prev_q) begin
          stab_cnt_d = (stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + 8'd1;
        end else begin
          stab_cnt_d = 8'd0;
        end
        // A pattern already handed over is not re-reported; the counter saturates while we wait.
        if (stab_cnt_d == STAB_MAX && !(reported_q && lamp_s == last_rep_q)) begin
          snap_d  = lamp_s;
          idx_d   = 4'd0;
          level_d = 5'd0;
          run_d   = 1'b1;
          bub_d   = 1'b0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        scan_bit = snap_q[idx_q];
`ifdef BUBBLE_TOLERANT_EN
        if (scan_bit) level_d = level_q + 5'd1;
`else
        if (scan_bit && run_q) level_d = level_q + 5'd1;
`endif
        if (!scan_bit) run_d = 1'b0;
        if (scan_bit && !run_q) bub_d = 1'b1;
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          code_d       = (level_d == 5'd16) ? 4'd15 : level_d[3:0];
          overflow_d   = (level_d == 5'd16);
          bubble_err_d = bub_d;
          state_d      = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (out_ready) begin
          last_rep_d = snap_q;
          reported_d = 1'b1;
          stab_cnt_d = 8'd0;
          state_d    = ST_SETTLE;
        end
      end

      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SETTLE;
      stab_cnt_q   <= '0;
      snap_q       <= '0;
      last_rep_q   <= '0;
      reported_q   <= 1'b0;
      idx_q        <= '0;
      level_q      <= '0;
      run_q        <= 1'b0;
      bub_q        <= 1'b0;
      code_q       <= '0;
      overflow_q   <= 1'b0;
      bubble_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stab_cnt_q   <= stab_cnt_d;
      snap_q       <= snap_d;
      last_rep_q   <= last_rep_d;
      reported_q   <= reported_d;
      idx_q        <= idx_d;
      level_q      <= level_d;
      run_q        <= run_d;
      bub_q        <= bub_d;
      code_q       <= code_d;
      overflow_q   <= overflow_d;
      bubble_err_q <= bubble_err_d;
    end
  end

  assign out_valid  = (state_q == ST_HOLD);
  assign busy       = (state_q != ST_SETTLE);
  assign code       = code_q;
  assign overflow   = overflow_q;
  assign bubble_err = bubble_err_q;

  // A stalled result must not move under the consumer.
  hold_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable({code, overflow, bubble_err})));

endmodule

// File: tb/tb_lamp_level_encoder.sv
// Directed bench for lamp_level_encoder: a vector table of patterns plus hand-written reset,
// stall, glitch-rejection and no-re-report sequences. Expected values follow BUBBLE_TOLERANT_EN.
module tb_lamp_level_encoder;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int LAT           = SYNC_STAGES + STABLE_CYCLES + 17;
  localparam int BUDGET        = 80;

  logic        clk;
  logic        rst_n;
  logic [15:0] lamp_in;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  code;
  logic        overflow;
  logic        bubble_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] lamp;
    logic [3:0]  code;
    logic        ovf;
    logic        bub;
  } vec_t;

  vec_t vecs[8];

  lamp_level_encoder #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lamp_in   (lamp_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .code      (code),
    .overflow  (overflow),
    .bubble_err(bubble_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 0;
    for (int n = 1; n <= BUDGET; n++) begin
      tick();
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check({name, " valid"}, out_valid, 1);
  endtask

  task automatic expect_report(input string name, input logic [3:0] exp_code, input logic exp_ovf,
                               input logic exp_bub, input bit check_lat);
    int lat;
    wait_valid(name, lat);
    if (check_lat) check({name, " latency in window"}, (lat >= LAT - 1 && lat <= LAT + 1), 1);
    check({name, " code"}, code, exp_code);
    check({name, " overflow"}, overflow, exp_ovf);
    check({name, " bubble_err"}, bubble_err, exp_bub);
    check({name, " busy"}, busy, 1);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " valid drops"}, out_valid, 0);
    check({name, " busy drops"}, busy, 0);
  endtask

  task automatic quiet(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check({name, " no out_valid"}, seen, 0);
  endtask

  initial begin
`ifdef BUBBLE_TOLERANT_EN
    vecs[0] = '{16'hFFFF, 4'd15, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 4'd15, 1'b0, 1'b0};
    vecs[2] = '{16'h00F3, 4'd6,  1'b0, 1'b1};
    vecs[3] = '{16'h0001, 4'd1,  1'b0, 1'b0};
    vecs[4] = '{16'h8000, 4'd1,  1'b0, 1'b1};
    vecs[5] = '{16'h00FF, 4'd8,  1'b0, 1'b0};
    vecs[6] = '{16'hFFFE, 4'd15, 1'b0, 1'b1};
    vecs[7] = '{16'h0000, 4'd0,  1'b0, 1'b0};
`else
    vecs[0] = '{16'hFFFF, 4'd15, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 4'd15, 1'b0, 1'b0};
    vecs[2] = '{16'h00F3, 4'd2,  1'b0, 1'b1};
    vecs[3] = '{16'h0001, 4'd1,  1'b0, 1'b0};
    vecs[4] = '{16'h8000, 4'd0,  1'b0, 1'b1};
    vecs[5] = '{16'h00FF, 4'd8,  1'b0, 1'b0};
    vecs[6] = '{16'hFFFE, 4'd0,  1'b0, 1'b1};
    vecs[7] = '{16'h0000, 4'd0,  1'b0, 1'b0};
`endif

    rst_n     = 1'b0;
    lamp_in   = 16'h00FF;
    out_ready = 1'b0;
    repeat (3) tick();
    check("reset state", {out_valid, code, overflow, bubble_err, busy}, 0);

    // Bring up with 00FF held, then hit reset while the result is pending.
    rst_n = 1'b1;
    expect_report("bringup 00FF", 4'd8, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n   = 1'b0;
    lamp_in = 16'h0000;
    #1;
    check("async reset clears outputs", {out_valid, code, overflow, bubble_err, busy}, 0);
    quiet("during reset", 3);
    rst_n = 1'b1;
    expect_report("post-reset 0000", 4'd0, 1'b0, 1'b0, 1'b0);
    handshake("post-reset 0000");
    quiet("0000 single report", 40);

    // Stalled consumer: outputs must hold for 10 cycles, then one transfer only.
    lamp_in = 16'h007F;
    expect_report("stall 007F", 4'd7, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 10; n++) begin
      tick();
      check("stall valid/code/flags", {out_valid, code, overflow, bubble_err}, {1'b1, 4'd7, 1'b0, 1'b0});
    end
    handshake("stall 007F");
    quiet("007F no re-report", 40);

    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d %04h", i, vecs[i].lamp);
      lamp_in = vecs[i].lamp;
      expect_report(nm, vecs[i].code, vecs[i].ovf, vecs[i].bub, 1'b1);
      handshake(nm);
    end

    // Glitchy input never settles long enough to report.
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i <= 18; i++) begin
        lamp_in = (i % 2 == 1) ? 16'h001F : 16'h000F;
        repeat (2) begin
          tick();
          if (out_valid) seen = 1'b1;
        end
      end
      check("toggling input no out_valid", seen, 0);
    end
    lamp_in = 16'h001F;
    expect_report("settled 001F", 4'd5, 1'b0, 1'b0, 1'b1);
    handshake("settled 001F");

    // Reset during a scan discards it; the same pattern is reported once afterwards.
    lamp_in = 16'h0003;
    repeat (12) tick();
    check("mid-scan busy", busy, 1);
    check("mid-scan not valid", out_valid, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset mid-scan clears outputs", {out_valid, code, overflow, bubble_err, busy}, 0);
    quiet("scan discarded", 3);
    rst_n = 1'b1;
    expect_report("rescan 0003", 4'd2, 1'b0, 1'b0, 1'b1);
    handshake("rescan 0003");
    quiet("0003 no re-report", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
